// File: rtl/cla_pipe_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_adder_pkg
//  Description : Shared definitions for the pipelined carry-lookahead
//                adder/subtractor: default geometry, segment-width
//                derivation and the legality check for a WIDTH/SEGS split.
//  Revision    : 1.0 - initial release
// ============================================================================
package cla_pipe_adder_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SEGS  = 4;

   // Operation selector as seen by the operand preprocessing logic
   typedef enum logic [0:0] {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Width of one pipeline segment; guards against a zero divisor
   function automatic int seg_width(input int width, input int segs);
      return (segs > 0) ? (width / segs) : width;
   endfunction

   // A split is usable when every stage gets an equal, non-empty slice
   function automatic bit seg_split_ok(input int width, input int segs);
      return (segs >= 1) && (segs <= width) && ((width % segs) == 0);
   endfunction

endpackage : cla_pipe_adder_pkg
`default_nettype wire

// File: rtl/cla_seg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_seg
//  Description : Combinational W-bit carry-lookahead segment. Every internal
//                carry is formed directly from generate/propagate prefixes
//                rather than rippling; group G/P are exported for callers
//                that want to build a higher lookahead level.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_seg #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         g,
   output logic         p,
   output logic         co
);

   logic [W-1:0] gen;
   logic [W-1:0] prop;
   logic [W:0]   carry;
   logic         gacc;
   logic         pacc;

   assign gen  = a & b;
   assign prop = a ^ b;

   // Lookahead: carry into bit i+1 is the OR of every generate term in
   // [i:0] qualified by the propagates above it, plus the fully
   // propagated carry-in. The final iteration yields the group terms.
   always_comb begin
      carry    = '0;
      carry[0] = ci;
      gacc     = 1'b0;
      pacc     = 1'b1;
      for (int i = 0; i < W; i++) begin
         gacc = gen[i];
         pacc = prop[i];
         for (int j = i - 1; j >= 0; j--) begin
            gacc = gacc | (pacc & gen[j]);
            pacc = pacc & prop[j];
         end
         carry[i+1] = gacc | (pacc & ci);
      end
      g = gacc;
      p = pacc;
   end

   assign s  = prop ^ carry[W-1:0];
   assign co = carry[W];

endmodule : cla_seg
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_adder
//  Description : Pipelined carry-lookahead adder/subtractor. Operands are
//                cut into SEGS slices; stage k resolves slice k and registers
//                the carry for stage k+1. One global advance enable drives
//                every stage, so bubbles are kept rather than squeezed out.
//                The last stage register is the output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_adder
   import cla_pipe_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEGS  = DEF_SEGS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf
);

   localparam int SEG_W = seg_width(WIDTH, SEGS);

   if (!seg_split_ok(WIDTH, SEGS)) begin : g_bad_split
      $error("cla_pipe_adder: WIDTH must be a non-zero multiple of SEGS");
   end

   op_e              op;
   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   // Whole pipe moves together unless a held result is being refused
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Subtraction is A + ~B + 1; the caller's carry-in is ignored then
   assign op      = op_e'(sub);
   assign b_eff   = (op == OP_SUB) ? ~b : b;
   assign cin_eff = (op == OP_SUB) ? 1'b1 : c_in;

   for (genvar k = 0; k < SEGS; k++) begin : g_stage
      // Bits of the operands still unresolved when entering this stage
      localparam int LO = k * SEG_W;
      localparam int HW = WIDTH - LO;

      logic [HW-1:0]         src_a;
      logic [HW-1:0]         src_b;
      logic                  src_c;
      logic                  src_v;
      logic [LO+SEG_W-1:0]   nxt_s;
      logic [SEG_W-1:0]      seg_s;
      logic                  seg_g;
      logic                  seg_p;
      logic                  seg_co;
      logic                  unused_grp;
      logic [LO+SEG_W-1:0]   s_q;
      logic                  c_q;
      logic                  v_q;

      if (k == 0) begin : g_head
         assign src_a = a;
         assign src_b = b_eff;
         assign src_c = cin_eff;
         assign src_v = in_valid;
         assign nxt_s = seg_s;
      end else begin : g_body
         assign src_a = g_stage[k-1].g_fwd.a_q;
         assign src_b = g_stage[k-1].g_fwd.b_q;
         assign src_c = g_stage[k-1].c_q;
         assign src_v = g_stage[k-1].v_q;
         assign nxt_s = {seg_s, g_stage[k-1].s_q};
      end

      cla_seg #(
         .W (SEG_W)
      ) u_seg (
         .a  (src_a[SEG_W-1:0]),
         .b  (src_b[SEG_W-1:0]),
         .ci (src_c),
         .s  (seg_s),
         .g  (seg_g),
         .p  (seg_p),
         .co (seg_co)
      );

      // Group terms are not needed: the carry is pipelined, not looked ahead
      assign unused_grp = seg_g ^ seg_p;

      // Stage register: valid shifts on every advance, payload only on valid
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (adv) begin
            v_q <= src_v;
            if (src_v) begin
               c_q <= seg_co;
               s_q <= nxt_s;
            end
         end
      end

      if (k < SEGS - 1) begin : g_fwd
         logic [HW-SEG_W-1:0] a_q;
         logic [HW-SEG_W-1:0] b_q;

         // Carry the still-unresolved high operand slices to the next stage
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv && src_v) begin
               a_q <= src_a[HW-1:SEG_W];
               b_q <= src_b[HW-1:SEG_W];
            end
         end
      end else begin : g_tail
         logic ovf_q;

         // Signed overflow from the operand sign bits and the new sum sign
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (adv && src_v) begin
               ovf_q <= (src_a[HW-1] == src_b[HW-1]) &&
                        (seg_s[SEG_W-1] != src_a[HW-1]);
            end
         end
      end
   end

   assign out_valid = g_stage[SEGS-1].v_q;
   assign s         = g_stage[SEGS-1].s_q;
   assign c_out     = g_stage[SEGS-1].c_q;
   assign ovf       = g_stage[SEGS-1].g_tail.ovf_q;

endmodule : cla_pipe_adder
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_pipe_adder
//  Description : Self-checking bench for cla_pipe_adder. Directed vectors,
//                streaming, stall and mid-stream reset on a 32/4 instance;
//                randomized traffic on 16/2, 32/1 and 64/8 instances checked
//                against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;

   localparam int N_RAND      = 10000;
   localparam int RAND_LIMIT  = 40000;
   localparam int CFG_W [3]   = '{16, 32, 64};
   localparam int CFG_S [3]   = '{2, 1, 8};

   logic clk;
   logic rst_n;
   logic start_rand;
   int   n_checks;
   int   n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for the whole bench
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: exact integer arithmetic; returns {ovf, c_out, s}
   function automatic logic [65:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic sb, input logic ci, input int w);
      logic [63:0]        mask;
      logic [65:0]        ua, ub, tot;
      logic signed [65:0] sa, sbv, sr, hi, lo;
      logic               c, v;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      ua   = {2'b00, a & mask};
      ub   = {2'b00, b & mask};
      sa   = $signed(ua << (66 - w)) >>> (66 - w);
      sbv  = $signed(ub << (66 - w)) >>> (66 - w);
      hi   = (66'sd1 <<< (w - 1)) - 66'sd1;
      lo   = -(66'sd1 <<< (w - 1));
      if (sb) begin
         tot = ua - ub;
         c   = (ua >= ub);
         sr  = sa - sbv;
      end else begin
         tot = ua + ub + {65'd0, ci};
         c   = ((tot >> w) != 66'd0);
         sr  = sa + sbv + $signed({65'd0, ci});
      end
      v = (sr > hi) || (sr < lo);
      return {v, c, tot[63:0] & mask};
   endfunction

   // Operand source biased toward carry-chain corner values
   function automatic logic [63:0] rnd_op(input int w);
      logic [63:0] v;
      case ($urandom_range(7))
         0:       v = '0;
         1:       v = '1;
         2:       v = 64'd1 << (w - 1);
         3:       v = (64'd1 << (w - 1)) - 64'd1;
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   // ---------------------------------------------------------------- main DUT
   logic        m_iv, m_ordy, m_sub, m_cin;
   logic [31:0] m_a, m_b, m_s;
   logic        m_ir, m_ov, m_co, m_of;
   logic [65:0] mq[$];

   cla_pipe_adder #(.WIDTH(32), .SEGS(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (m_iv),
      .in_ready  (m_ir),
      .a         (m_a),
      .b         (m_b),
      .c_in      (m_cin),
      .sub       (m_sub),
      .out_valid (m_ov),
      .out_ready (m_ordy),
      .s         (m_s),
      .c_out     (m_co),
      .ovf       (m_of)
   );

   task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sb, input logic ci, input logic [31:0] es,
                          input logic ec, input logic ev);
      int n;
      @(posedge clk); #1;
      m_iv = 1'b1; m_a = a; m_b = b; m_sub = sb; m_cin = ci; m_ordy = 1'b1;
      chk({tag, "_in_ready"}, m_ir, 1);
      @(posedge clk); #1;
      m_iv = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_ov && n < 20);
      chk({tag, "_latency"}, n, 4);
      chk({tag, "_s"}, m_s, es);
      chk({tag, "_c_out"}, m_co, ec);
      chk({tag, "_ovf"}, m_of, ev);
   endtask

   task automatic new_op();
      m_a   = 32'(rnd_op(32));
      m_b   = 32'(rnd_op(32));
      m_sub = 1'($urandom_range(1));
      m_cin = 1'($urandom_range(1));
   endtask

   task automatic pop_cmp(input string tag);
      logic [65:0] e;
      if (mq.size() == 0) begin
         chk({tag, "_unexpected"}, m_ov, 0);
      end else begin
         e = mq.pop_front();
         chk({tag, "_s"}, m_s, e[31:0]);
         chk({tag, "_c_out"}, m_co, e[64]);
         chk({tag, "_ovf"}, m_of, e[65]);
      end
   endtask

   // ------------------------------------------------------- random instances
   for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
      localparam int W = CFG_W[gi];
      localparam int S = CFG_S[gi];

      logic          iv, ordy, sb, ci, ir, ov, co, of, done;
      logic [W-1:0]  ra, rb, rs;
      logic [65:0]   q[$];

      cla_pipe_adder #(.WIDTH(W), .SEGS(S)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (iv),
         .in_ready  (ir),
         .a         (ra),
         .b         (rb),
         .c_in      (ci),
         .sub       (sb),
         .out_valid (ov),
         .out_ready (ordy),
         .s         (rs),
         .c_out     (co),
         .ovf       (of)
      );

      initial begin : p_rand
         int          sent, got, cyc;
         bit          need;
         logic [65:0] e;
         string       tg;
         iv = 1'b0; ordy = 1'b0; sb = 1'b0; ci = 1'b0;
         ra = '0; rb = '0; done = 1'b0;
         sent = 0; got = 0; cyc = 0; need = 1'b1;
         tg = $sformatf("w%0d_seg%0d", W, S);
         wait (start_rand);
         while (got < N_RAND && cyc < RAND_LIMIT) begin
            @(posedge clk); #1;
            ordy = ($urandom_range(3) != 0);
            if (need) begin
               ra = W'(rnd_op(W));
               rb = W'(rnd_op(W));
               sb = 1'($urandom_range(1));
               ci = 1'($urandom_range(1));
               iv = (sent < N_RAND) && ($urandom_range(4) != 0);
            end
            @(negedge clk);
            cyc++;
            if (ov && ordy) begin
               if (q.size() == 0) begin
                  chk({tg, "_unexpected"}, ov, 0);
               end else begin
                  e = q.pop_front();
                  chk({tg, "_s"}, rs, e[W-1:0]);
                  chk({tg, "_c_out"}, co, e[64]);
                  chk({tg, "_ovf"}, of, e[65]);
               end
               got++;
            end
            if (iv && ir) begin
               q.push_back(ref_model(64'(ra), 64'(rb), sb, ci, W));
               sent++;
               need = 1'b1;
            end else begin
               need = !iv;
            end
         end
         chk({tg, "_results"}, got, N_RAND);
         done = 1'b1;
      end
   end

   // ----------------------------------------------------------- main sequence
   initial begin : p_main
      int  got, sent;
      bit  need;
      n_checks = 0; n_fail = 0; start_rand = 1'b0;
      rst_n = 1'b0;
      m_iv = 1'b0; m_ordy = 1'b1; m_sub = 1'b0; m_cin = 1'b0; m_a = '0; m_b = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready_during", m_ir, 1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", m_ov, 0);
      chk("rst_s", m_s, 0);
      chk("rst_c_out", m_co, 0);
      chk("rst_ovf", m_of, 0);
      chk("rst_in_ready", m_ir, 1);

      // Directed vectors
      run_vec("carry_chain", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      run_vec("pos_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      run_vec("sub_borrow",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_vec("add_cin",     32'h0000_00FF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
      run_vec("neg_ovf_sub", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

      // Back-to-back stream: 8 ops in cycles 0..7, results in cycles 4..11
      mq.delete();
      for (int c = 0; c < 14; c++) begin
         @(posedge clk); #1;
         m_ordy = 1'b1;
         if (c < 8) begin
            m_iv = 1'b1;
            new_op();
         end else begin
            m_iv = 1'b0;
         end
         @(negedge clk);
         if (c < 8) chk("b2b_in_ready", m_ir, 1);
         chk("b2b_out_valid", m_ov, (c >= 4 && c < 12));
         if (m_ov) pop_cmp("b2b");
         if (m_iv && m_ir) mq.push_back(ref_model(64'(m_a), 64'(m_b), m_sub, m_cin, 32));
      end
      chk("b2b_drained", mq.size(), 0);

      // Stall with full pipe for cycles 4..8, release from cycle 9
      mq.delete();
      got = 0; sent = 0; need = 1'b1;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk); #1;
         m_ordy = (c >= 9);
         if (need) begin
            if (sent < 6) begin
               m_iv = 1'b1;
               new_op();
            end else begin
               m_iv = 1'b0;
            end
         end
         @(negedge clk);
         if (c >= 4 && c <= 8) begin
            chk("stall_in_ready", m_ir, 0);
            chk("stall_out_valid", m_ov, 1);
            if (mq.size() > 0) chk("stall_s_hold", m_s, mq[0][31:0]);
         end
         if (m_ov && m_ordy) begin
            pop_cmp("stall");
            got++;
         end
         if (m_iv && m_ir) begin
            mq.push_back(ref_model(64'(m_a), 64'(m_b), m_sub, m_cin, 32));
            sent++;
            need = 1'b1;
         end else begin
            need = !m_iv;
         end
      end
      chk("stall_result_count", got, 6);
      chk("stall_drained", mq.size(), 0);

      // Mid-stream asynchronous reset: one result held, three in flight
      mq.delete();
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         m_ordy = 1'b0;
         m_iv   = 1'b1;
         new_op();
      end
      @(posedge clk); #1;
      m_iv = 1'b0;
      chk("pre_rst_out_valid", m_ov, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", m_ov, 0);
      chk("async_rst_s", m_s, 0);
      chk("async_rst_in_ready", m_ir, 1);
      @(negedge clk);
      rst_n = 1'b1;
      m_ordy = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("post_rst_no_stale", m_ov, 0);
      end
      chk("post_rst_in_ready", m_ir, 1);

      // Randomized traffic on the other geometries
      start_rand = 1'b1;
      for (int i = 0; i < RAND_LIMIT + 100; i++) begin
         if (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) break;
         @(posedge clk);
      end
      chk("rand_all_done", {g_cfg[2].done, g_cfg[1].done, g_cfg[0].done}, 3'b111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : p_watchdog
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule : tb_cla_pipe_adder
`default_nettype wire

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the fixed 32-bit single-cycle CLA wrapper.
- WIDTH-bit operands are split into SEGS segments. Each pipeline stage resolves one segment through a combinational CLA and registers the carry into the next stage.
- Valid/ready handshakes on input and output allow use inside stallable datapaths, e.g. the ALU accumulate path and the address generator.
- Adds subtract mode, carry-out and signed-overflow flags.

Parameters:
WIDTH, 32, operand/result width in bits; must be divisible by SEGS.
SEGS, 4, number of pipeline segments (1..WIDTH); latency in cycles.
SEG_W, WIDTH/SEGS, derived segment width; not overridden by users.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand transfer request.
in_ready  output  1  block can accept operands this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
c_in  input  1  carry-in (add mode only).
sub  input  1  1 = A - B, 0 = A + B + c_in.
out_valid  output  1  result present at output.
out_ready  input  1  downstream accepts result.
s  output  WIDTH  sum/difference.
c_out  output  1  carry out of MSB; in subtract mode, 1 = no borrow.
ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async assert, sync deassert by system): all stage valid bits cleared; out_valid=0, s=0, c_out=0, ovf=0.
  - in_ready is 1 during and after reset.
  - Any in-flight operations are discarded.
- Operand preprocessing at acceptance:
  - b_eff = sub ? ~b : b.
  - cin_eff = sub ? 1 : c_in; c_in is ignored when sub=1.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv.
  - A transfer occurs when in_valid && in_ready.
- Stage k (0..SEGS-1):
  - On adv, stage k+1 captures stage k's registered state.
  - Stage k computes segment k with the cla_seg sub-module, using the registered carry from stage k-1 (cin_eff for k=0).
  - Remaining high segments of a and b_eff travel unmodified; completed low result segments travel forward.
  - Stage valid bits shift on adv. Stage 0 valid = in_valid && in_ready.
- Latency: exactly SEGS cycles from acceptance to out_valid when unstalled. Throughput is 1 result per cycle.
- Stall (out_valid && !out_ready):
  - All stages hold; in_ready=0.
  - s, c_out and ovf stay stable until accepted.
- Bubbles are not compressed: an empty stage still occupies a slot. This is intentional to keep a single global enable.
- ovf = (a_msb == b_eff_msb) && (s_msb != a_msb), computed in the final stage from the carried MSBs.
- SEGS=1 degenerates to one registered stage, latency 1.
- Wrap-around: the sum is modulo 2^WIDTH; the high bit is reported only via c_out.
- Simultaneous out_ready and in_valid while full: result leaves and new operand enters in the same cycle; no loss.
- X on a, b or sub while in_valid=0 must not propagate to out_valid.

Decomposition:
- Shared header (cla_defs): default WIDTH/SEGS and the SEG_W derivation localparam; compile-time check that WIDTH % SEGS == 0.
- Sub-module cla_seg #(W): combinational W-bit carry-lookahead.
  - Inputs a, b, ci.
  - Outputs s, group g, group p, co.
  - Instantiated SEGS times via generate.
- Top holds only pipeline registers and handshake logic.

Test Plan:
- WIDTH=32, SEGS=4, out_ready=1: a=0x0000_0001, b=0xFFFF_FFFF, sub=0, c_in=0 -> after 4 cycles s=0x0000_0000, c_out=1, ovf=0 (carry crosses all segments).
- a=0x7FFF_FFFF, b=0x0000_0001, sub=0 -> s=0x8000_0000, c_out=0, ovf=1; a=5, b=7, sub=1, c_in=1 -> s=0xFFFF_FFFE, c_out=0, ovf=0 (c_in ignored).
- Back-to-back stream of 8 operand pairs with out_ready=1 -> in_ready stays 1; 8 results on consecutive cycles, cycles 4..11, in order.
- Hold out_ready=0 with pipeline full for 5 cycles -> in_ready=0; s stable; no result dropped or duplicated after release.
- Assert rst_n=0 mid-stream with 3 ops in flight -> out_valid=0 immediately (async); after release no stale results appear; in_ready=1.
- Random a, b, sub, c_in over WIDTH=16/SEGS=2, WIDTH=32/SEGS=1, WIDTH=64/SEGS=8, random out_ready -> s, c_out and ovf match reference model for 10k ops.
